// File: rtl/xadac_vrf_wb_if.sv
// xadac_vrf_wb_if: result handshake bundle between the producers (execute/load
// units) and the VRF write-back front end. One valid/ready/id/data lane per producer.
interface xadac_vrf_wb_if #(
    parameter int NumSrc = 2,
    parameter int IdW    = 5,
    parameter int DATA_W = 64
);
    logic [NumSrc-1:0]             src_valid;
    logic [NumSrc-1:0]             src_ready;
    logic [NumSrc-1:0][IdW-1:0]    src_id;
    logic [NumSrc-1:0][DATA_W-1:0] src_data;

    modport master (output src_valid, output src_id, output src_data, input src_ready);
    modport slave  (input src_valid, input src_id, input src_data, output src_ready);
endinterface

// File: rtl/xadac_vrf_wb.sv
// xadac_vrf_wb: write-back front end of the xadac vector register file.
// Round-robin merge of NumSrc producers onto the single VRF write port through one
// registered stage, plus the per-register pending scoreboard used for RAW/WAW checks.
// Optional feature: define XADAC_VRF_WB_FWD_EN to drive fwd_hit/fwd_data from the
// write port; otherwise those outputs are tied to zero and rd_id is ignored.
module xadac_vrf_wb #(
    parameter int NumSrc = 2,
    parameter int VrfLen = 32,
    parameter int DATA_W = 64,
    parameter int IdW    = (VrfLen > 1) ? $clog2(VrfLen) : 1
) (
    input  logic                clk,
    input  logic                rst,
    xadac_vrf_wb_if.slave       src,
    input  logic                rsv_valid,
    input  logic [IdW-1:0]      rsv_id,
    output logic                rsv_ready,
    output logic [VrfLen-1:0]   busy,
    output logic [IdW-1:0]      vrf_wid,
    output logic [DATA_W-1:0]   vrf_wdata,
    output logic                vrf_we,
    output logic                err_spur,
    input  logic [2:0][IdW-1:0] rd_id,
    output logic [2:0]          fwd_hit,
    output logic [DATA_W-1:0]   fwd_data
);
    localparam int PtrW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

    logic [PtrW-1:0]   rr_ptr;
    logic [VrfLen-1:0] pending;
    logic [VrfLen-1:0] pending_nxt;
    logic              gnt_any;
    logic [PtrW-1:0]   gnt_idx;
    logic              gnt_fire;
    logic              rsv_fire;

    // Source index base+off, wrapping at NumSrc.
    function automatic logic [PtrW-1:0] wrap_idx(input logic [PtrW-1:0] base, input int off);
        return PtrW'((int'(base) + off) % NumSrc);
    endfunction

    // Round-robin search: first valid source at or after rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NumSrc; k++) begin
            if (!gnt_any && src.src_valid[wrap_idx(rr_ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(rr_ptr, k);
            end
        end
    end

    // Nothing is accepted while reset is held.
    assign gnt_fire = gnt_any && !rst;

    // One-hot ready back to the granted producer.
    always_comb begin
        src.src_ready = '0;
        if (gnt_fire) begin
            src.src_ready[gnt_idx] = 1'b1;
        end
    end

    // WAW stall, relaxed when the blocking write retires this very cycle.
    assign rsv_ready = !rst && (!pending[rsv_id] || (vrf_we && (vrf_wid == rsv_id)));
    assign rsv_fire  = rsv_valid && rsv_ready;

    // Pointer advances past the winner only when something was granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_fire) begin
            rr_ptr <= wrap_idx(gnt_idx, 1);
        end
    end

    // ---- stage boundary: grant -> VRF write port (one cycle) ----
    // Registered write port; id/data hold their last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vrf_we    <= 1'b0;
            vrf_wid   <= '0;
            vrf_wdata <= '0;
        end else begin
            vrf_we <= gnt_fire;
            if (gnt_fire) begin
                vrf_wid   <= src.src_id[gnt_idx];
                vrf_wdata <= src.src_data[gnt_idx];
            end
        end
    end

    // Scoreboard update: retire clears, reservation sets; set is applied last so it wins.
    always_comb begin
        pending_nxt = pending;
        if (vrf_we) begin
            pending_nxt[vrf_wid] = 1'b0;
        end
        if (rsv_fire) begin
            pending_nxt[rsv_id] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign busy = pending;

    // Sticky flag for a write retiring to a register nobody reserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_spur <= 1'b0;
        end else if (vrf_we && !pending[vrf_wid]) begin
            err_spur <= 1'b1;
        end
    end

`ifdef XADAC_VRF_WB_FWD_EN
    // Readers see the value the VRF captures at the coming edge.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fwd_hit[i] = vrf_we && (vrf_wid == rd_id[i]);
        end
    end
    assign fwd_data = vrf_wdata;
`else
    logic unused_rd;
    assign unused_rd = ^rd_id;
    assign fwd_hit   = 3'b000;
    assign fwd_data  = '0;
`endif

endmodule
